// File: rtl/mem_stage.sv
// Memory-access stage: issues request/ack accesses to a multi-cycle data memory,
// stalls the upstream pipeline while an access is outstanding, and holds MEM/WB.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ex_alu_out,
   input  logic [15:0] ex_store_data,
   input  logic [3:0]  ex_dst,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_reg_write,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic [15:0] wb_data,
   output logic [3:0]  wb_dst,
   output logic        wb_reg_write,
   output logic        mem_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] TimeoutVal = 4'(TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic        memReq_q, memReq_d;
   logic        memWr_q, memWr_d;
   logic [15:0] memAddr_q, memAddr_d;
   logic [15:0] memWdata_q, memWdata_d;
   logic [15:0] wbData_q, wbData_d;
   logic [3:0]  wbDst_q, wbDst_d;
   logic        wbRegWrite_q, wbRegWrite_d;
   logic        memErr_q, memErr_d;
   logic        stallInt;
   logic        memop;

   assign memop = ex_mem_read | ex_mem_write;

   // DONE behaves like IDLE; it only forces mem_req low for one cycle between accesses.
   // An ack is honoured only in BUSY, where mem_req is guaranteed high.
   always_comb begin
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      memReq_d     = memReq_q;
      memWr_d      = memWr_q;
      memAddr_d    = memAddr_q;
      memWdata_d   = memWdata_q;
      wbData_d     = 16'h0000;
      wbDst_d      = 4'h0;
      wbRegWrite_d = 1'b0;
      memErr_d     = memErr_q;
      stallInt     = 1'b0;
      case (state_q)
         BUSY: begin
            if (mem_ack) begin
               state_d      = DONE;
               memReq_d     = 1'b0;
               wbData_d     = ex_mem_to_reg ? mem_rdata : ex_alu_out;
               wbDst_d      = ex_dst;
               wbRegWrite_d = ex_reg_write;
            end else if (waitCnt_q == TimeoutVal) begin
               state_d  = DONE;
               memReq_d = 1'b0;
               wbDst_d  = ex_dst;
               memErr_d = 1'b1;
            end else begin
               stallInt  = 1'b1;
               waitCnt_d = (waitCnt_q == 4'hF) ? waitCnt_q : waitCnt_q + 4'd1;
            end
         end
         default: begin
            if (memop) begin
               stallInt   = 1'b1;
               state_d    = BUSY;
               waitCnt_d  = 4'h0;
               memReq_d   = 1'b1;
               memWr_d    = ex_mem_write;
               memAddr_d  = ex_alu_out;
               memWdata_d = ex_store_data;
            end else begin
               state_d      = IDLE;
               memReq_d     = 1'b0;
               wbData_d     = ex_alu_out;
               wbDst_d      = ex_dst;
               wbRegWrite_d = ex_reg_write;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         waitCnt_q    <= 4'h0;
         memReq_q     <= 1'b0;
         memWr_q      <= 1'b0;
         memAddr_q    <= 16'h0000;
         memWdata_q   <= 16'h0000;
         wbData_q     <= 16'h0000;
         wbDst_q      <= 4'h0;
         wbRegWrite_q <= 1'b0;
         memErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         waitCnt_q    <= waitCnt_d;
         memReq_q     <= memReq_d;
         memWr_q      <= memWr_d;
         memAddr_q    <= memAddr_d;
         memWdata_q   <= memWdata_d;
         wbData_q     <= wbData_d;
         wbDst_q      <= wbDst_d;
         wbRegWrite_q <= wbRegWrite_d;
         memErr_q     <= memErr_d;
      end
   end

   assign stall        = rst & stallInt;
   assign mem_req      = memReq_q;
   assign mem_wr       = memWr_q;
   assign mem_addr     = memAddr_q;
   assign mem_wdata    = memWdata_q;
   assign wb_data      = wbData_q;
   assign wb_dst       = wbDst_q;
   assign wb_reg_write = wbRegWrite_q;
   assign mem_err      = memErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a behavioural memory answers requests after a
// programmed number of BUSY cycles and a scoreboard queue holds expected MEM/WB results.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] exAluOut = 16'h0, exStoreData = 16'h0, memRdata = 16'h0;
   logic [3:0]  exDst = 4'h0;
   logic        exMemRead = 1'b0, exMemWrite = 1'b0, exMemToReg = 1'b0, exRegWrite = 1'b0;
   logic        memAck = 1'b0;
   logic        memReq, memWr, stall, wbRegWrite, memErr;
   logic [15:0] memAddr, memWdata, wbData;
   logic [3:0]  wbDst;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dst;
      logic        regWrite;
   } wbExp_t;

   wbExp_t expQ[$];
   int     testCount = 0;
   int     failCount = 0;
   logic   expErr = 1'b0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .ex_alu_out(exAluOut), .ex_store_data(exStoreData), .ex_dst(exDst),
      .ex_mem_read(exMemRead), .ex_mem_write(exMemWrite),
      .ex_mem_to_reg(exMemToReg), .ex_reg_write(exRegWrite),
      .mem_req(memReq), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .mem_ack(memAck), .stall(stall),
      .wb_data(wbData), .wb_dst(wbDst), .wb_reg_write(wbRegWrite), .mem_err(memErr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one EX/MEM instruction, plays the memory (ack on BUSY cycle ackCycle, 0 = never),
   // then checks the MEM/WB result against the queued expectation.
   task automatic applyStimulus(input logic [15:0] alu, input logic [15:0] sdata,
                                input logic [15:0] rdata, input logic [3:0] dst,
                                input logic rd, input logic wr, input logic m2r, input logic rw,
                                input int ackCycle, input int expStall,
                                input logic spurious, input logic checkGap);
      logic   isMem;
      logic   isTimeout;
      wbExp_t e;
      int     stallCnt = 0;
      int     busyCnt = 0;
      int     reqLow = 0;
      int     cyc = 0;
      logic   done = 1'b0;
      logic   addrChecked = 1'b0;
      isMem     = rd | wr;
      isTimeout = isMem && (ackCycle == 0);
      e.data     = isTimeout ? 16'h0 : ((isMem && m2r) ? rdata : alu);
      e.dst      = dst;
      e.regWrite = isTimeout ? 1'b0 : rw;
      expQ.push_back(e);
      if (isTimeout) expErr = 1'b1;

      exAluOut = alu; exStoreData = sdata; memRdata = rdata; exDst = dst;
      exMemRead = rd; exMemWrite = wr; exMemToReg = m2r; exRegWrite = rw;
      memAck = 1'b0;

      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (memReq) begin
            busyCnt++;
            if (!addrChecked) begin
               addrChecked = 1'b1;
               checkOutput("memAddr", 32'(memAddr), 32'(alu));
               checkOutput("memWr", 32'(memWr), 32'(wr));
               checkOutput("memWdata", 32'(memWdata), 32'(sdata));
            end
            if (busyCnt == ackCycle) memAck = 1'b1;
         end else begin
            reqLow++;
            if (spurious && cyc == 1) memAck = 1'b1;
         end
         #1;
         if (stall) begin
            stallCnt++;
            if (stallCnt > 1) checkOutput("bubble", 32'(wbRegWrite), 32'd0);
         end else begin
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         memAck = 1'b0;
      end
      checkOutput("cycleBudget", 32'(done), 32'd1);

      e = expQ.pop_front();
      checkOutput("wbData", 32'(wbData), 32'(e.data));
      checkOutput("wbDst", 32'(wbDst), 32'(e.dst));
      checkOutput("wbRegWrite", 32'(wbRegWrite), 32'(e.regWrite));
      checkOutput("stallCycles", 32'(stallCnt), 32'(expStall));
      checkOutput("reqLowAfter", 32'(memReq), 32'd0);
      checkOutput("memErr", 32'(memErr), 32'(expErr));
      if (checkGap) checkOutput("reqGap", 32'(reqLow), 32'd1);
   endtask

   initial begin
      #12;
      checkOutput("rstReq", 32'(memReq), 32'd0);
      checkOutput("rstStall", 32'(stall), 32'd0);
      checkOutput("rstAddr", 32'(memAddr), 32'd0);
      checkOutput("rstWb", 32'({wbData, wbDst, wbRegWrite}), 32'd0);
      checkOutput("rstErr", 32'(memErr), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // ALU-only, load ack on 3rd BUSY, store then immediate load, load without mem_to_reg
      applyStimulus(16'h1234, 16'h0, 16'h0, 4'd3, 0, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(16'h0040, 16'h0, 16'hBEEF, 4'd5, 1, 0, 1, 1, 3, 3, 0, 0);
      applyStimulus(16'h0010, 16'h00AA, 16'h0, 4'd0, 0, 1, 0, 0, 1, 1, 0, 0);
      applyStimulus(16'h0020, 16'h0, 16'h5A5A, 4'd6, 1, 0, 1, 1, 2, 2, 0, 1);
      applyStimulus(16'h0033, 16'h0, 16'h7777, 4'd8, 1, 0, 0, 1, 1, 1, 0, 1);
      // Read and write both set is a write
      applyStimulus(16'h0050, 16'h1111, 16'h2222, 4'd2, 1, 1, 0, 0, 1, 1, 0, 1);
      // Timeout: 15 stalled BUSY cycles plus the IDLE cycle
      applyStimulus(16'h0080, 16'h0, 16'hDEAD, 4'd7, 1, 0, 1, 1, 0, 16, 0, 0);
      applyStimulus(16'h4321, 16'h0, 16'h0, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0);
      // Spurious ack while idle
      applyStimulus(16'hABCD, 16'h0, 16'hFFFF, 4'd9, 0, 0, 0, 1, 0, 0, 1, 0);

      // Reset in the middle of an access
      exAluOut = 16'h0090; exMemRead = 1'b1; exMemWrite = 1'b0;
      exMemToReg = 1'b1; exRegWrite = 1'b1; exDst = 4'd1; memAck = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("preRstReq", 32'(memReq), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midRstReq", 32'(memReq), 32'd0);
      checkOutput("midRstStall", 32'(stall), 32'd0);
      checkOutput("midRstWb", 32'({wbData, wbDst, wbRegWrite}), 32'd0);
      checkOutput("midRstErr", 32'(memErr), 32'd0);
      expErr = 1'b0;
      exMemRead = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(16'h5555, 16'h0, 16'h0, 4'd10, 0, 0, 0, 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined processor. It sits directly downstream of the EX/MEM pipeline register and consumes that register's ALU result, store data, destination register and control bits (MemRead, MemWrite, MemToReg, RegWrite). It runs a request/acknowledge handshake with a multi-cycle data memory and asserts `stall` to freeze the upstream pipeline registers while an access is in flight. It also contains the MEM/WB pipeline register feeding writeback.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum BUSY cycles to wait for `mem_ack` before aborting.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ex_alu_out`  in  16  ALU result; this is the memory address for loads and stores.
- `ex_store_data`  in  16  store data.
- `ex_dst`  in  4  destination register number.
- `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`  in  1 each  control bits from EX/MEM.
- `mem_req`  out  1  memory request; registered.
- `mem_wr`  out  1  1 = write, 0 = read; registered.
- `mem_addr`  out  16  memory address; registered.
- `mem_wdata`  out  16  memory write data; registered.
- `mem_rdata`  in  16  read data; valid only in the `mem_ack` cycle.
- `mem_ack`  in  1  single-cycle completion pulse from memory.
- `stall`  out  1  combinational; holds EX/MEM and all earlier pipeline registers (drives their write enable low).
- `wb_data`  out  16  MEM/WB register: writeback value.
- `wb_dst`  out  4  MEM/WB register: destination register.
- `wb_reg_write`  out  1  MEM/WB register: register-file write enable.
- `mem_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- `memop` = `ex_mem_read | ex_mem_write`. If both bits are set, the access is a write.
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE, `memop` = 0:**
  - `stall` = 0.
  - MEM/WB loads `wb_data` = `ex_alu_out`, plus `ex_dst` and `ex_reg_write`.
- **IDLE, `memop` = 1:**
  - `stall` = 1.
  - Next edge: `mem_req` goes to 1 and `mem_addr`, `mem_wdata` and `mem_wr` are latched; the FSM moves to BUSY.
  - MEM/WB loads a bubble (all fields 0).
- **BUSY:**
  - `mem_req` stays high; address, data and `wr` are held stable.
  - While no ack has arrived: `stall` = 1, MEM/WB loads a bubble, and the wait counter increments.
- **BUSY with `mem_ack` = 1:**
  - `stall` = 0 in that same cycle.
  - Next edge:
    - MEM/WB loads `wb_data` = `ex_mem_to_reg ? mem_rdata : ex_alu_out`, plus `ex_dst` and `ex_reg_write`.
    - `mem_req` goes to 0.
    - The FSM moves to DONE.
- **DONE:**
  - `mem_req` = 0.
  - The FSM behaves exactly as IDLE for the newly arrived EX/MEM contents.
  - DONE exists only to guarantee that `mem_req` has at least one low cycle between back-to-back accesses.
- **Timeout:** if the wait counter reaches `TIMEOUT` in BUSY with no ack, the instruction is treated as an ack cycle with these differences:
  - `wb_data` = 0 and `wb_reg_write` = 0.
  - `mem_err` is set to 1.
- An ack that arrives while `mem_req` = 0 is ignored.
- Stores with `ex_reg_write` = 0 produce `wb_reg_write` = 0. No store data reaches writeback.

## Timing
- Values on reset assertion (asynchronous):
  - State = IDLE, wait counter = 0.
  - `mem_req`, `mem_wr` = 0; `mem_addr`, `mem_wdata` = 0.
  - `wb_data`, `wb_dst`, `wb_reg_write` = 0.
  - `mem_err` = 0.
  - `stall` = 0 while `rst` is low.
- Reset mid-access drops `mem_req` immediately; the memory must tolerate an abandoned request.
- Non-memory instruction: 1 cycle. EX/MEM to MEM/WB in one edge, no stall.
- Memory instruction with ack on the k-th cycle of BUSY (k ≥ 1):
  - `stall` is high for k cycles: the IDLE cycle plus k−1 BUSY cycles.
  - The result appears on `wb_*` after k+1 edges.
- The wait counter is 4 bits and saturates; `TIMEOUT` must be ≤ 15.
- Back-to-back memory ops: DONE → stall → BUSY, so `mem_req` is low for exactly 1 cycle between accesses.

## Test plan
- **ALU-only stream:** `ex_alu_out` = 16'h1234, `ex_dst` = 3, `ex_reg_write` = 1, no memop.
  - Required: `stall` = 0 throughout.
  - Required: the next edge gives `wb_data` = 16'h1234, `wb_dst` = 3, `wb_reg_write` = 1.
- **Load with ack on the 3rd BUSY cycle:** address 16'h0040, `mem_rdata` = 16'hBEEF, `ex_mem_to_reg` = 1.
  - Required: `stall` high for 3 cycles, `mem_addr` = 16'h0040, `mem_wr` = 0.
  - Required: `wb_data` = 16'hBEEF one edge after the ack.
  - Required: bubbles (`wb_reg_write` = 0) during the stall.
- **Store, then immediate load:** store 16'h00AA to 16'h0010 (ack in the 1st BUSY cycle), then a load.
  - Required: `mem_wr` = 1 with `mem_wdata` = 16'h00AA.
  - Required: `mem_req` low for exactly 1 cycle between the two requests.
  - Required: the store gives `wb_reg_write` = 0.
- **Timeout:** load with no ack and `TIMEOUT` = 15.
  - Required: after 15 BUSY cycles, `stall` drops and `mem_err` = 1 (sticky).
  - Required: `wb_reg_write` = 0 and `wb_data` = 0.
- **Reset mid-access:** assert `rst` low during BUSY.
  - Required: `mem_req`, `stall` and all `wb_*` outputs go to 0 immediately, before the next clock.
  - Required: after release, an ALU-only op completes normally.
- **Spurious ack:** `mem_ack` pulsed while IDLE with no memop.
  - Required: no state change, `wb_data` = ALU value.
